// File: rtl/id_stage_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU-op classes, control-bit positions and
// immediate formats, plus the immediate generator used by the decode stage.
package id_stage_pkg;

  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcJal    = 7'b1101111;

  localparam logic [2:0] AluAdd = 3'd0;
  localparam logic [2:0] AluR   = 3'd1;
  localparam logic [2:0] AluI   = 3'd2;
  localparam logic [2:0] AluBr  = 3'd3;
  localparam logic [2:0] AluLui = 3'd4;

  localparam int unsigned CtrlRegWrite = 7;
  localparam int unsigned CtrlMemRead  = 6;
  localparam int unsigned CtrlMemWrite = 5;
  localparam int unsigned CtrlMemtoReg = 4;
  localparam int unsigned CtrlAluSrc   = 3;
  localparam int unsigned CtrlBranch   = 2;
  localparam int unsigned CtrlJal      = 1;
  localparam int unsigned CtrlJalr     = 0;

  typedef enum logic [2:0] {ImmNone, ImmI, ImmS, ImmB, ImmU, ImmJ} imm_fmt_e;

  function automatic logic [31:0] gen_imm(input logic [31:0] inst, input imm_fmt_e fmt);
    logic [31:0] imm;
    case (fmt)
      ImmI:    imm = {{20{inst[31]}}, inst[31:20]};
      ImmS:    imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      ImmB:    imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      ImmU:    imm = {inst[31:12], 12'b0};
      ImmJ:    imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = 32'b0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// ID/EX pipeline-register bundle: the decode stage drives it (master), execute consumes it (slave).
interface id_stage_if;
  logic [31:0] ID_stage_pc_o;
  logic [31:0] ID_stage_pc_add4_o;
  logic [31:0] ID_stage_rs1_data_o;
  logic [31:0] ID_stage_rs2_data_o;
  logic [31:0] ID_stage_imm_o;
  logic [4:0]  ID_stage_rs1_o;
  logic [4:0]  ID_stage_rs2_o;
  logic [4:0]  ID_stage_rd_o;
  logic [2:0]  ID_stage_funct3_o;
  logic        ID_stage_funct7b5_o;
  logic [2:0]  ID_stage_aluop_o;
  logic [7:0]  ID_stage_ctrl_o;

  modport master (
    output ID_stage_pc_o, ID_stage_pc_add4_o, ID_stage_rs1_data_o, ID_stage_rs2_data_o,
           ID_stage_imm_o, ID_stage_rs1_o, ID_stage_rs2_o, ID_stage_rd_o, ID_stage_funct3_o,
           ID_stage_funct7b5_o, ID_stage_aluop_o, ID_stage_ctrl_o
  );

  modport slave (
    input ID_stage_pc_o, ID_stage_pc_add4_o, ID_stage_rs1_data_o, ID_stage_rs2_data_o,
          ID_stage_imm_o, ID_stage_rs1_o, ID_stage_rs2_o, ID_stage_rd_o, ID_stage_funct3_o,
          ID_stage_funct7b5_o, ID_stage_aluop_o, ID_stage_ctrl_o
  );
endinterface

// File: rtl/id_stage_reg_file.sv
// 32x32 register file: x0 hard-wired to zero, synchronous write, combinational reads that
// return the write-back value when it targets the register being read in the same cycle.
module reg_file (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_raddr1,
  input  logic [4:0]  i_raddr2,
  output logic [31:0] o_rdata1,
  output logic [31:0] o_rdata2
);

  logic [31:0] r_regs [32];
  logic        w_wr_en;

  assign w_wr_en = i_we && (i_waddr != 5'd0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'b0;
    end else if (w_wr_en) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  always_comb begin
    o_rdata1 = 32'b0;
    o_rdata2 = 32'b0;
    if (i_raddr1 != 5'd0) o_rdata1 = (w_wr_en && i_waddr == i_raddr1) ? i_wdata : r_regs[i_raddr1];
    if (i_raddr2 != 5'd0) o_rdata2 = (w_wr_en && i_waddr == i_raddr2) ? i_wdata : r_regs[i_raddr2];
  end

endmodule

// File: rtl/id_stage.sv
// RV32I instruction-decode stage: decode, register read, immediate generation, load-use
// hazard detection, wrong-path squash and the ID/EX pipeline register.
module id_stage
  import id_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ID_stage_pc_i,
  input  logic [31:0] ID_stage_pc_add4_i,
  input  logic [31:0] ID_stage_inst_i,
  input  logic        ID_stage_PCSrc_i,
  input  logic        ID_stage_ex_memread_i,
  input  logic [4:0]  ID_stage_ex_rd_i,
  input  logic        ID_stage_wb_we_i,
  input  logic [4:0]  ID_stage_wb_rd_i,
  input  logic [31:0] ID_stage_wb_data_i,
  output logic        ID_stage_hd_PCWrite_o,
  output logic        ID_stage_hd_Write_o,
  id_stage_if.master  id_ex
);

  logic        r_kill;
  logic        w_valid, w_stall, w_bubble;
  logic        w_legal, w_use_rs1, w_use_rs2;
  logic [7:0]  w_ctrl;
  logic [2:0]  w_aluop;
  imm_fmt_e    w_fmt;
  logic [4:0]  w_rs1, w_rs2, w_rd;
  logic [31:0] w_rs1_data, w_rs2_data;

  always_comb begin
    w_legal   = 1'b1;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_ctrl    = 8'b0;
    w_aluop   = AluAdd;
    w_fmt     = ImmNone;
    case (ID_stage_inst_i[6:0])
      OpcOp: begin
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_aluop = AluR;
        w_ctrl[CtrlRegWrite] = 1'b1;
      end
      OpcOpImm: begin
        w_use_rs1 = 1'b1; w_aluop = AluI; w_fmt = ImmI;
        w_ctrl[CtrlRegWrite] = 1'b1; w_ctrl[CtrlAluSrc] = 1'b1;
      end
      OpcLoad: begin
        w_use_rs1 = 1'b1; w_fmt = ImmI;
        w_ctrl[CtrlRegWrite] = 1'b1; w_ctrl[CtrlMemRead] = 1'b1;
        w_ctrl[CtrlMemtoReg] = 1'b1; w_ctrl[CtrlAluSrc]  = 1'b1;
      end
      OpcStore: begin
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_fmt = ImmS;
        w_ctrl[CtrlMemWrite] = 1'b1; w_ctrl[CtrlAluSrc] = 1'b1;
      end
      OpcBranch: begin
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_aluop = AluBr; w_fmt = ImmB;
        w_ctrl[CtrlBranch] = 1'b1;
      end
      OpcJal: begin
        w_fmt = ImmJ;
        w_ctrl[CtrlRegWrite] = 1'b1; w_ctrl[CtrlJal] = 1'b1;
      end
      OpcJalr: begin
        w_use_rs1 = 1'b1; w_fmt = ImmI;
        w_ctrl[CtrlRegWrite] = 1'b1; w_ctrl[CtrlAluSrc] = 1'b1; w_ctrl[CtrlJalr] = 1'b1;
      end
      OpcLui: begin
        w_aluop = AluLui; w_fmt = ImmU;
        w_ctrl[CtrlRegWrite] = 1'b1; w_ctrl[CtrlAluSrc] = 1'b1;
      end
      OpcAuipc: begin
        w_fmt = ImmU;
        w_ctrl[CtrlRegWrite] = 1'b1; w_ctrl[CtrlAluSrc] = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Unused source/destination fields are zeroed so they never alias a real register.
  assign w_rs1 = w_use_rs1 ? ID_stage_inst_i[19:15] : 5'd0;
  assign w_rs2 = w_use_rs2 ? ID_stage_inst_i[24:20] : 5'd0;
  assign w_rd  = w_ctrl[CtrlRegWrite] ? ID_stage_inst_i[11:7] : 5'd0;

  reg_file u_reg_file (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_we     (ID_stage_wb_we_i),
    .i_waddr  (ID_stage_wb_rd_i),
    .i_wdata  (ID_stage_wb_data_i),
    .i_raddr1 (w_rs1),
    .i_raddr2 (w_rs2),
    .o_rdata1 (w_rs1_data),
    .o_rdata2 (w_rs2_data)
  );

  // Squash both wrong-path slots: the one in ID now and the one fetched during redirect.
  assign w_valid  = ~(ID_stage_PCSrc_i | r_kill);
  assign w_stall  = w_valid & ID_stage_ex_memread_i & (ID_stage_ex_rd_i != 5'd0) &
                    ((w_use_rs1 & (ID_stage_ex_rd_i == w_rs1)) |
                     (w_use_rs2 & (ID_stage_ex_rd_i == w_rs2)));
  assign w_bubble = ~w_valid | w_stall;

  assign ID_stage_hd_PCWrite_o = rst | ~w_stall;
  assign ID_stage_hd_Write_o   = rst | ~w_stall;

  always_ff @(posedge clk) begin
    if (rst) r_kill <= 1'b0;
    else     r_kill <= ID_stage_PCSrc_i;
  end

  always_ff @(posedge clk) begin
    if (rst || w_bubble) begin
      id_ex.ID_stage_pc_o       <= 32'b0;
      id_ex.ID_stage_pc_add4_o  <= 32'b0;
      id_ex.ID_stage_rs1_data_o <= 32'b0;
      id_ex.ID_stage_rs2_data_o <= 32'b0;
      id_ex.ID_stage_imm_o      <= 32'b0;
      id_ex.ID_stage_rs1_o      <= 5'b0;
      id_ex.ID_stage_rs2_o      <= 5'b0;
      id_ex.ID_stage_rd_o       <= 5'b0;
      id_ex.ID_stage_funct3_o   <= 3'b0;
      id_ex.ID_stage_funct7b5_o <= 1'b0;
      id_ex.ID_stage_aluop_o    <= 3'b0;
      id_ex.ID_stage_ctrl_o     <= 8'b0;
    end else begin
      id_ex.ID_stage_pc_o       <= ID_stage_pc_i;
      id_ex.ID_stage_pc_add4_o  <= ID_stage_pc_add4_i;
      id_ex.ID_stage_rs1_data_o <= w_rs1_data;
      id_ex.ID_stage_rs2_data_o <= w_rs2_data;
      id_ex.ID_stage_imm_o      <= gen_imm(ID_stage_inst_i, w_fmt);
      id_ex.ID_stage_rs1_o      <= w_rs1;
      id_ex.ID_stage_rs2_o      <= w_rs2;
      id_ex.ID_stage_rd_o       <= w_rd;
      id_ex.ID_stage_funct3_o   <= w_legal ? ID_stage_inst_i[14:12] : 3'b0;
      id_ex.ID_stage_funct7b5_o <= w_legal & ID_stage_inst_i[30];
      id_ex.ID_stage_aluop_o    <= w_aluop;
      id_ex.ID_stage_ctrl_o     <= w_ctrl;
    end
  end

endmodule
